// File: rtl/vga_timing_checker.sv
// Watches an incoming VGA sync/colour stream, verifies line and frame timing,
// locks after two clean frames and captures the colour of one visible pixel per frame.
module vga_timing_checker #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        mhz_clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [3:0]  probe_red,
    output logic [3:0]  probe_green,
    output logic [3:0]  probe_blue,
    output logic        probe_valid,
    output logic [15:0] frame_count
);
    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [11:0] H_OFS_W   = 12'(H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
    localparam logic [10:0] V_OFS_W   = 11'(V_SYNC + V_BP);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [10:0] hcnt_q, hcnt_d, hlow_q, hlow_d;
    logic [9:0]  vcnt_q, vcnt_d, vhf_q, vhf_d;
    logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic        h_err_q, h_err_d, v_err_q, v_err_d;
    logic [1:0]  good_q, good_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [9:0]  probe_x_q, probe_x_d;
    logic [8:0]  probe_y_q, probe_y_d;
    logic [11:0] probe_rgb_q, probe_rgb_d;
    logic        probe_valid_q, probe_valid_d;

    logic hfall, hrise, vfall, vrise, err_seen, frame_ok;

    assign hfall    = pix_en & hs_prev_q & ~hsync;
    assign hrise    = pix_en & ~hs_prev_q & hsync;
    assign vfall    = pix_en & vs_prev_q & ~vsync;
    assign vrise    = pix_en & ~vs_prev_q & vsync;
    // Errors act on the FSM one cycle after their pulse, so locked trails the pulse.
    assign err_seen = h_err_q | v_err_q;
    assign frame_ok = vfall & ~h_err_d & ~v_err_d & ~err_seen;

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        hcnt_d        = hcnt_q;
        hlow_d        = hlow_q;
        vcnt_d        = vcnt_q;
        vhf_d         = vhf_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        probe_x_d     = probe_x_q;
        probe_y_d     = probe_y_q;
        probe_rgb_d   = probe_rgb_q;
        h_err_d       = 1'b0;
        v_err_d       = 1'b0;
        probe_valid_d = 1'b0;
        if (pix_en) begin
            hs_prev_d = hsync;
            vs_prev_d = vsync;
            probe_x_d = probe_x;
            probe_y_d = probe_y;

            if (hfall)                  hcnt_d = '0;
            else if (hcnt_q != 11'h7FF) hcnt_d = hcnt_q + 11'd1;
            if (hfall && h_seen_q && ({1'b0, hcnt_q} + 12'd1 != H_TOTAL_W))
                h_err_d = 1'b1;
            if (hfall) h_seen_d = 1'b1;

            if (hfall)                             hlow_d = 11'd1;
            else if (!hsync && hlow_q != 11'h7FF) hlow_d = hlow_q + 11'd1;
            if (hrise && hlow_q != H_SYNC_W) h_err_d = 1'b1;

            if (vfall)                           vcnt_d = '0;
            else if (hfall && vcnt_q != 10'h3FF) vcnt_d = vcnt_q + 10'd1;
            if (vfall && v_seen_q && ({1'b0, vcnt_q} + {10'd0, hfall} != V_TOTAL_W))
                v_err_d = 1'b1;
            if (vfall) v_seen_d = 1'b1;

            // Line starts seen while vsync is low, including the one coinciding with the fall.
            if (vfall)                                  vhf_d = {9'd0, hfall};
            else if (!vsync && hfall && vhf_q != 10'h3FF) vhf_d = vhf_q + 10'd1;
            if (vrise && vhf_q != V_SYNC_W) v_err_d = 1'b1;

            if (state_q == LOCKED && probe_x_q < 10'd640 && probe_y_q < 9'd480
                && {1'b0, hcnt_d} == H_OFS_W + {2'b0, probe_x_q}
                && {1'b0, vcnt_d} == V_OFS_W + {2'b0, probe_y_q}) begin
                probe_rgb_d   = {red, green, blue};
                probe_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        good_d        = good_q;
        frame_count_d = frame_count_q;
        if (state_q == HUNT && vfall)            good_d = 2'd0;
        if (state_q == CHECK && frame_ok)        good_d = good_q + 2'd1;
        if (state_q == LOCKED && frame_ok)       frame_count_d = frame_count_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (vfall) state_d = CHECK;
            CHECK:   if (err_seen) state_d = HUNT;
                     else if (frame_ok && good_q == 2'd1) state_d = LOCKED;
            LOCKED:  if (err_seen) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge mhz_clk) begin
        if (reset) begin
            state_q       <= HUNT;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcnt_q        <= '0;
            hlow_q        <= '0;
            vcnt_q        <= '0;
            vhf_q         <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            good_q        <= '0;
            frame_count_q <= '0;
            probe_x_q     <= '0;
            probe_y_q     <= '0;
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            hlow_q        <= hlow_d;
            vcnt_q        <= vcnt_d;
            vhf_q         <= vhf_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            good_q        <= good_d;
            frame_count_q <= frame_count_d;
            probe_x_q     <= probe_x_d;
            probe_y_q     <= probe_y_d;
            probe_rgb_q   <= probe_rgb_d;
            probe_valid_q <= probe_valid_d;
        end
    end

    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign probe_red   = probe_rgb_q[11:8];
    assign probe_green = probe_rgb_q[7:4];
    assign probe_blue  = probe_rgb_q[3:0];
    assign probe_valid = probe_valid_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker on a scaled-down raster (20x12) with a
// pixel strobe every 4th clock; expected values are worked out by hand below.
module tb_vga_timing_checker;
    localparam int HT = 20, HS = 4, HB = 3, VT = 12, VS = 2, VB = 3;
    localparam int ALL = 1 << 30;

    logic        mhz_clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic [9:0]  probe_x = '0;
    logic [8:0]  probe_y = '0;
    logic        locked, h_err, v_err, probe_valid;
    logic [3:0]  probe_red, probe_green, probe_blue;
    logic [15:0] frame_count;

    vga_timing_checker #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .mhz_clk(mhz_clk), .reset(reset), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .h_err(h_err), .v_err(v_err),
        .probe_red(probe_red), .probe_green(probe_green), .probe_blue(probe_blue),
        .probe_valid(probe_valid), .frame_count(frame_count)
    );

    always #5 mhz_clk = ~mhz_clk;

    int passed = 0, total = 0;
    int cur_x = 0, cur_y = 0;
    int h_cnt = 0, v_cnt = 0, pv_cnt = 0, lock_cyc = 0, cyc = 0;
    int herr_x = -1, herr_y = -1, herr_cyc = 0, fall_cyc = 0;
    logic locked_prev = 1'b0;

    always @(negedge mhz_clk) begin
        if (h_err) begin
            h_cnt++;
            herr_x = cur_x;
            herr_y = cur_y;
            herr_cyc = cyc;
        end
        if (v_err) v_cnt++;
        if (probe_valid) pv_cnt++;
        if (locked) lock_cyc++;
        if (locked_prev && !locked) fall_cyc = cyc;
        locked_prev = locked;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One pixel: strobe for one clock, then three idle clocks.
    task automatic px(input int x, input int y, input int hsw);
        cur_x = x;
        cur_y = y;
        hsync = (x < hsw) ? 1'b0 : 1'b1;
        vsync = (y < VS) ? 1'b0 : 1'b1;
        if (x == HS + HB && y == VS + VB) begin
            red = 4'hA; green = 4'h5; blue = 4'h3;
        end else begin
            red = 4'(x); green = 4'(y); blue = 4'(x + y);
        end
        pix_en = 1'b1;
        @(posedge mhz_clk);
        #1 pix_en = 1'b0;
        repeat (3) @(posedge mhz_clk);
        #1;
    endtask

    // Frame of nlines lines; pixels whose running index lies in [first,last] are driven.
    task automatic frame(input int nlines, input int short_y, input int narrow_y,
                         input int first, input int last);
        int idx, npix, hsw;
        idx = 0;
        for (int y = 0; y < nlines; y++) begin
            npix = (y == short_y) ? HT - 1 : HT;
            hsw  = (y == narrow_y) ? HS - 1 : HS;
            for (int x = 0; x < npix; x++) begin
                if (idx >= first && idx <= last) px(x, y, hsw);
                idx++;
            end
        end
    endtask

    int snap;

    initial begin
        repeat (3) @(posedge mhz_clk);
        #1 reset = 1'b0;
        check("rst_locked", locked, 0);
        check("rst_h_err", h_err, 0);
        check("rst_v_err", v_err, 0);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_probe_rgb", {probe_red, probe_green, probe_blue}, 0);

        // Clean frames: first vsync fall enters CHECK, locks at the third.
        frame(VT, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, ALL);
        check("lock_not_yet", locked, 0);
        frame(VT, -1, -1, 0, 0);
        check("lock_rise", locked, 1);
        check("lock_no_h_err", h_cnt, 0);
        check("lock_no_v_err", v_cnt, 0);
        frame(VT, -1, -1, 1, ALL);
        check("probe00_count", pv_cnt, 1);
        check("probe00_rgb", {probe_red, probe_green, probe_blue}, 12'hA53);
        frame(VT, -1, -1, 0, ALL);
        check("probe00_count2", pv_cnt, 2);
        check("frame_count_1", frame_count, 1);

        // Probe (2,1) lands on pixel 9 of line 6: colour 9/6/F.
        probe_x = 10'd2; probe_y = 9'd1;
        frame(VT, -1, -1, 0, ALL);
        check("probe21_count", pv_cnt, 3);
        check("probe21_rgb", {probe_red, probe_green, probe_blue}, 12'h96F);
        check("frame_count_2", frame_count, 2);

        probe_x = 10'd640; probe_y = 9'd0;
        frame(VT, -1, -1, 0, ALL);
        check("probe640_count", pv_cnt, 3);
        check("probe640_hold", {probe_red, probe_green, probe_blue}, 12'h96F);

        // Line 6 one pixel short: error at the next hsync fall (line 7, pixel 0).
        frame(VT, 6, -1, 0, ALL);
        check("short_h_err_cnt", h_cnt, 1);
        check("short_h_err_x", herr_x, 0);
        check("short_h_err_y", herr_y, 7);
        check("short_unlocked", locked, 0);
        check("short_lock_lag", fall_cyc - herr_cyc, 1);
        frame(VT, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, ALL);
        check("short_relock_not_yet", locked, 0);
        frame(VT, -1, -1, 0, 0);
        check("short_relock", locked, 1);
        check("short_single_pulse", h_cnt, 1);
        check("frame_count_hold", frame_count, 4);
        frame(VT, -1, -1, 1, ALL);

        // Line 3 hsync low for only 3 pixels: error at the rise (pixel 3).
        frame(VT, -1, 3, 0, ALL);
        check("narrow_h_err_cnt", h_cnt, 2);
        check("narrow_h_err_x", herr_x, 3);
        check("narrow_h_err_y", herr_y, 3);
        check("narrow_unlocked", locked, 0);
        check("frame_count_5", frame_count, 5);

        // Frames one line short: v_err at every frame end, never locks.
        snap = lock_cyc;
        frame(VT - 1, -1, -1, 0, ALL);
        frame(VT - 1, -1, -1, 0, ALL);
        frame(VT - 1, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, ALL);
        check("short_frame_v_err", v_cnt, 3);
        check("short_frame_no_lock", lock_cyc - snap, 0);
        check("short_frame_no_h_err", h_cnt, 2);

        // Relock, then reset mid-frame in the visible area.
        frame(VT, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, 0);
        check("pre_reset_locked", locked, 1);
        frame(VT, -1, -1, 1, 6 * HT + 10);
        check("pre_reset_frame_count", frame_count, 5);
        reset = 1'b1;
        @(posedge mhz_clk);
        #1 reset = 1'b0;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_h_err", h_err, 0);
        check("mid_rst_v_err", v_err, 0);
        check("mid_rst_probe_valid", probe_valid, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_probe_rgb", {probe_red, probe_green, probe_blue}, 0);
        frame(VT, -1, -1, 6 * HT + 11, ALL);
        frame(VT, -1, -1, 0, ALL);
        frame(VT, -1, -1, 0, ALL);
        check("rst_relock_not_yet", locked, 0);
        frame(VT, -1, -1, 0, 0);
        check("rst_relock", locked, 1);
        check("rst_no_h_err", h_cnt, 2);
        check("rst_no_v_err", v_cnt, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
